// File: rtl/testbench_timer.sv
// 8-bit APB timer: prescaled up/down counter preloaded from TDR, with sticky
// overflow/underflow flags that are also driven out as interrupt lines.
`timescale 1ns/1ps
module testbench_timer (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic       tmr_ovf,
    output logic       tmr_udf
);
    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;

    logic [7:0] r_tdr;
    logic       r_load;
    logic       r_updw;
    logic       r_en;
    logic [1:0] r_cks;
    logic       r_ovf;
    logic       r_udf;
    logic [7:0] r_tcnt;
    logic [3:0] r_presc;

    logic       w_access;
    logic       w_wr;
    logic       w_addr_ok;
    logic       w_wr_tdr;
    logic       w_wr_tcr;
    logic       w_wr_tsr;
    logic       w_presc_clr;
    logic       w_tick;
    logic       w_ovf_set;
    logic       w_udf_set;
    logic [3:0] w_mask;
    logic [7:0] w_tcr_rd;

    assign w_access  = psel & penable;
    assign w_wr      = w_access & pwrite;
    assign w_addr_ok = (paddr[7:2] == 6'd0);
    assign w_wr_tdr  = w_wr & (paddr == ADDR_TDR);
    assign w_wr_tcr  = w_wr & (paddr == ADDR_TCR);
    assign w_wr_tsr  = w_wr & (paddr == ADDR_TSR);

    assign pready  = w_access;
    assign pslverr = w_access & ~w_addr_ok;
    assign tmr_ovf = r_ovf;
    assign tmr_udf = r_udf;

    // Tick when the low CKS+1 prescaler bits are all ones: period 2^(CKS+1),
    // and a CKS change applies from the next count without a restart.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mask
            if (gi == 0) begin : g_lsb
                assign w_mask[gi] = 1'b1;
            end else begin : g_hi
                assign w_mask[gi] = (r_cks >= 2'(gi));
            end
        end
    endgenerate

    assign w_presc_clr = ~r_en | r_load;
    assign w_tick      = ~w_presc_clr & ((r_presc & w_mask) == w_mask);
    assign w_ovf_set   = w_tick & ~r_updw & (r_tcnt == 8'hFF);
    assign w_udf_set   = w_tick &  r_updw & (r_tcnt == 8'h00);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_presc <= 4'd0;
        end else if (w_presc_clr) begin
            r_presc <= 4'd0;
        end else begin
            r_presc <= r_presc + 4'd1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_tcnt <= 8'h00;
        end else if (r_load) begin
            r_tcnt <= r_tdr;
        end else if (w_tick) begin
            r_tcnt <= r_updw ? (r_tcnt - 8'd1) : (r_tcnt + 8'd1);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_tdr  <= 8'h00;
            r_load <= 1'b0;
            r_updw <= 1'b0;
            r_en   <= 1'b0;
            r_cks  <= 2'b00;
        end else begin
            if (w_wr_tdr) begin
                r_tdr <= pwdata;
            end
            if (w_wr_tcr) begin
                r_load <= pwdata[7];
                r_updw <= pwdata[5];
                r_en   <= pwdata[4];
                r_cks  <= pwdata[1:0];
            end
        end
    end

    // Hardware set has priority over a same-cycle write-zero clear.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~(w_wr_tsr & ~pwdata[0]));
            r_udf <= w_udf_set | (r_udf & ~(w_wr_tsr & ~pwdata[1]));
        end
    end

    assign w_tcr_rd = {r_load, 1'b0, r_updw, r_en, 2'b00, r_cks};

    always_comb begin
        prdata = 8'h00;
        if (psel && !pwrite) begin
            case (paddr)
                ADDR_TDR:  prdata = r_tdr;
                ADDR_TCR:  prdata = w_tcr_rd;
                ADDR_TSR:  prdata = {6'd0, r_udf, r_ovf};
                ADDR_TCNT: prdata = r_tcnt;
                default:   prdata = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_testbench_timer.sv
// Randomized APB bench for testbench_timer, compared every cycle against a
// behavioural model, plus hand-computed checks of the documented scenarios.
`timescale 1ns/1ps
module tb_testbench_timer;
    logic       pclk    = 1'b0;
    logic       presetn = 1'b0;
    logic       psel    = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite  = 1'b0;
    logic [7:0] paddr   = 8'h00;
    logic [7:0] pwdata  = 8'h00;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       tmr_ovf;
    logic       tmr_udf;

    int vectors     = 0;
    int miscompares = 0;

    testbench_timer dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .tmr_ovf (tmr_ovf),
        .tmr_udf (tmr_udf)
    );

    always #5 pclk = ~pclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: registers as plain integers, prescaler as elapsed
    // cycles since it was last held cleared.
    int m_tdr   = 0;
    int m_tcr   = 0;
    int m_cnt   = 0;
    int m_ovf   = 0;
    int m_udf   = 0;
    int m_phase = 0;

    function automatic bit model_tick();
        return (m_tcr[4] == 1'b1) && (m_tcr[7] == 1'b0) &&
               (((m_phase + 1) % (2 << m_tcr[1:0])) == 0);
    endfunction

    function automatic int exp_rd(input logic [7:0] a);
        case (a)
            8'h00:   return m_tdr;
            8'h01:   return m_tcr;
            8'h02:   return m_udf * 2 + m_ovf;
            8'h03:   return m_cnt;
            default: return 0;
        endcase
    endfunction

    wire m_wr = psel & penable & pwrite;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            m_tdr   <= 0;
            m_tcr   <= 0;
            m_cnt   <= 0;
            m_ovf   <= 0;
            m_udf   <= 0;
            m_phase <= 0;
        end else begin
            m_phase <= (m_tcr[4] == 1'b0 || m_tcr[7] == 1'b1) ? 0 : m_phase + 1;
            if (m_tcr[7] == 1'b1)
                m_cnt <= m_tdr;
            else if (model_tick())
                m_cnt <= (m_tcr[5] == 1'b1) ? (m_cnt + 255) % 256 : (m_cnt + 1) % 256;
            m_ovf <= ((model_tick() && m_tcr[7] == 1'b0 && m_tcr[5] == 1'b0 && m_cnt == 255) ||
                      (m_ovf == 1 && !(m_wr && paddr == 8'h02 && !pwdata[0]))) ? 1 : 0;
            m_udf <= ((model_tick() && m_tcr[7] == 1'b0 && m_tcr[5] == 1'b1 && m_cnt == 0) ||
                      (m_udf == 1 && !(m_wr && paddr == 8'h02 && !pwdata[1]))) ? 1 : 0;
            if (m_wr && paddr == 8'h00) m_tdr <= int'(pwdata);
            if (m_wr && paddr == 8'h01) m_tcr <= int'(pwdata & 8'hB3);
        end
    end

    always @(negedge pclk) begin
        check("prdata",  16'(prdata),  16'((psel && !pwrite) ? exp_rd(paddr) : 0));
        check("pready",  16'(pready),  16'(psel && penable));
        check("pslverr", 16'(pslverr), 16'(psel && penable && paddr > 8'h03));
        check("tmr_ovf", 16'(tmr_ovf), 16'(m_ovf));
        check("tmr_udf", 16'(tmr_udf), 16'(m_udf));
    end

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d, output logic e);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        #2 e = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        $display("WR  addr=0x%02h data=0x%02h err=%0b", a, d, e);
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [7:0] d, output logic e);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge pclk); #1;
        penable = 1'b1;
        #2 d = prdata; e = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        $display("RD  addr=0x%02h data=0x%02h err=%0b", a, d, e);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic e;
        apb_write(a, d, e);
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       e;
        apb_read(a, d, e);
        check(name, 16'(d), 16'(exp));
    endtask

    // Stop, clear flags, set reload value, then start with the given TCR.
    task automatic arm(input logic [7:0] tdr, input logic [7:0] tcr);
        wr(8'h01, 8'h80);
        wr(8'h02, 8'h00);
        wr(8'h00, tdr);
        wr(8'h01, tcr);
    endtask

    task automatic cycles_to_ovf(output int cycles);
        cycles = 0;
        while (tmr_ovf !== 1'b1 && cycles < 2000) begin
            @(posedge pclk); #1;
            cycles++;
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       e;
        int         cyc;
        logic [7:0] a;
        logic [7:0] v;

        repeat (3) @(posedge pclk);
        #2 presetn = 1'b1;

        // Reset state
        check("reset_ovf", 16'(tmr_ovf), 16'h0);
        check("reset_udf", 16'(tmr_udf), 16'h0);
        for (int i = 0; i < 4; i++) begin
            apb_read(8'(i), d, e);
            check("reset_reg", 16'(d), 16'h00);
            check("reset_pslverr", 16'(e), 16'h0);
        end

        // Clock-by-4 up-count overflow
        wr(8'h00, 8'h79);
        wr(8'h01, 8'h80);
        wr(8'h01, 8'h11);
        repeat (100) @(posedge pclk);
        rd_check("div4_tsr_early", 8'h02, 8'h00);
        repeat (921) @(posedge pclk);
        rd_check("div4_tsr_late", 8'h02, 8'h01);
        check("div4_tmr_ovf", 16'(tmr_ovf), 16'h1);
        wr(8'h02, 8'h00);
        rd_check("div4_tsr_cleared", 8'h02, 8'h00);

        // Exact overflow latency of the same example: 135 ticks of 4 pclk
        arm(8'h79, 8'h11);
        cycles_to_ovf(cyc);
        check("example_ovf_cycles", 16'(cyc), 16'd540);

        // Clock-by-2 down-count underflow
        arm(8'h05, 8'h30);
        repeat (20) @(posedge pclk);
        rd_check("down_tsr", 8'h02, 8'h02);
        apb_read(8'h03, d, e);
        check("down_tcnt_wrapped", 16'(d >= 8'hF0), 16'h1);

        // LOAD priority
        arm(8'h3C, 8'h90);
        repeat (100) @(posedge pclk);
        rd_check("load_tcnt", 8'h03, 8'h3C);
        rd_check("load_tsr", 8'h02, 8'h00);

        // CKS sweep: two ticks from 0xFE to overflow
        for (int c = 0; c < 4; c++) begin
            arm(8'hFE, 8'h10 | 8'(c));
            cycles_to_ovf(cyc);
            check("cks_sweep_cycles", 16'(cyc), 16'(2 * (2 << c)));
        end

        // Bus errors and write-only-zero flag semantics
        wr(8'h01, 8'h80);
        wr(8'h02, 8'h00);
        apb_read(8'h10, d, e);
        check("bad_read_prdata", 16'(d), 16'h00);
        check("bad_read_pslverr", 16'(e), 16'h1);
        apb_write(8'h10, 8'h55, e);
        check("bad_write_pslverr", 16'(e), 16'h1);
        apb_write(8'h03, 8'hAA, e);
        check("tcnt_write_pslverr", 16'(e), 16'h0);
        rd_check("tcnt_write_ignored", 8'h03, 8'hFE);
        wr(8'h02, 8'hFF);
        rd_check("tsr_write_one", 8'h02, 8'h00);
        rd_check("tcr_readback", 8'h01, 8'h80);
        wr(8'h01, 8'hFF);
        rd_check("tcr_ro_bits", 8'h01, 8'hB3);

        // Clear landing on the same edge as the overflow tick (/4, tick at +4)
        arm(8'hFF, 8'h11);
        @(posedge pclk);
        wr(8'h02, 8'h00);
        rd_check("race_ovf_kept", 8'h02, 8'h01);

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            int r;
            r = $urandom_range(0, 5);
            a = (r < 4) ? 8'(r) : 8'($urandom_range(4, 255));
            v = 8'($urandom);
            if (a == 8'h01) begin
                if ($urandom_range(0, 3) == 0) v = v | 8'h80;
                else v = (v & 8'h7F) | 8'h10;
            end
            if (a == 8'h00 && $urandom_range(0, 1) == 1) v = 8'hF0 | v;
            if ($urandom_range(0, 1) == 1) apb_write(a, v, e);
            else apb_read(a, d, e);
            repeat ($urandom_range(0, 8)) @(posedge pclk);
        end

        // Asynchronous reset mid-count with a flag set
        arm(8'hFF, 8'h10);
        repeat (6) @(posedge pclk);
        #1 check("pre_reset_ovf", 16'(tmr_ovf), 16'h1);
        @(posedge pclk); #2;
        presetn = 1'b0;
        #1 check("midreset_ovf", 16'(tmr_ovf), 16'h0);
        check("midreset_udf", 16'(tmr_udf), 16'h0);
        psel = 1'b1; pwrite = 1'b0; paddr = 8'h01;
        #1 check("midreset_tcr", 16'(prdata), 16'h00);
        psel = 1'b0;
        @(posedge pclk); #2;
        presetn = 1'b1;
        repeat (10) @(posedge pclk);
        rd_check("post_reset_tcnt", 8'h03, 8'h00);
        rd_check("post_reset_tdr", 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
